// File: rtl/core_pkg.sv
// Shared constants for the MUSA core front end: pc_src encodings,
// the NOP encoding used to flush IF/ID, and the fetch FSM state codes.
package core_pkg;

    // pc_src encodings driven by decode
    localparam logic [2:0] PCSRC_SEQ = 3'd0;
    localparam logic [2:0] PCSRC_BR  = 3'd1;
    localparam logic [2:0] PCSRC_J   = 3'd2;
    localparam logic [2:0] PCSRC_JR  = 3'd3;
    localparam logic [2:0] PCSRC_RET = 3'd4;

    // All-zero word decodes as a NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // True for the pc_src codes that change control flow; 5-7 act as sequential
    function automatic logic is_redirect_src(input logic [2:0] src);
        return (src == PCSRC_BR) || (src == PCSRC_J) ||
               (src == PCSRC_JR) || (src == PCSRC_RET);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection. Produces the word-aligned target,
// a flag telling whether decode asked for a control-flow change, and
// a flag telling whether the raw target was not word aligned.
module next_pc_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic [2:0]  pc_src,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jump_jpc,
    input  logic [31:0] reg_target,
    input  logic [31:0] stack_target,
    output logic [31:0] target,
    output logic        misalign,
    output logic        redirect
);

    logic [31:0] raw_target;

    // Select the raw destination; branch is relative to the IF/ID PC+4
    always_comb begin
        raw_target = pc + 32'd4;
        case (pc_src)
            PCSRC_BR:  raw_target = pc_plus4 + (branch_offset << 2);
            PCSRC_J:   raw_target = {pc_plus4[31:28], jump_jpc[27:0]};
            PCSRC_JR:  raw_target = reg_target;
            PCSRC_RET: raw_target = stack_target;
            default:   raw_target = pc + 32'd4;
        endcase
    end

    assign redirect = is_redirect_src(pc_src);
    // Low bits are dropped rather than trapping; the caller reports it
    assign target   = {raw_target[31:2], 2'b00};
    assign misalign = redirect && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ready handshake, applies decode redirects and stalls, and drives the
// IF/ID register. A redirect that arrives while a request is still waiting
// for ready is remembered and applied once that request retires, so the
// address seen by memory never changes mid-transaction.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    input  logic               pc_write,
    input  logic [2:0]         pc_src,
    input  logic [31:0]        branch_offset,
    input  logic [31:0]        jump_jpc,
    input  logic [31:0]        reg_target,
    input  logic [31:0]        stack_target,
    output logic [31:0]        instruction,
    output logic [31:0]        pc_plus4,
    output logic               if_valid,
    output logic               fetch_misalign,
    output logic [COUNT_W-1:0] fetch_count
);

    logic [1:0]         state_q,      state_d;
    logic [31:0]        pc_q,         pc_d;
    logic [31:0]        instr_q,      instr_d;
    logic [31:0]        pc4_q,        pc4_d;
    logic               valid_q,      valid_d;
    logic               misalign_q,   misalign_d;
    logic [COUNT_W-1:0] count_q,      count_d;
    logic [31:0]        hold_q,       hold_d;
    logic [31:0]        hold_pc4_q,   hold_pc4_d;
    logic               discard_q,    discard_d;
    logic [31:0]        disc_tgt_q,   disc_tgt_d;

    logic [31:0] calc_target;
    logic        calc_misalign;
    logic        calc_redirect;
    logic        take_redirect;
    logic [31:0] seq_pc;

    next_pc_calc u_next_pc_calc (
        .pc            (pc_q),
        .pc_plus4      (pc4_q),
        .pc_src        (pc_src),
        .branch_offset (branch_offset),
        .jump_jpc      (jump_jpc),
        .reg_target    (reg_target),
        .stack_target  (stack_target),
        .target        (calc_target),
        .misalign      (calc_misalign),
        .redirect      (calc_redirect)
    );

    // pc_src is only meaningful while decode lets the PC advance
    assign take_redirect = pc_write && calc_redirect;
    assign seq_pc        = pc_q + 32'd4;

    // Next-state logic: redirect beats stall beats sequential fetch
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        count_d    = count_q;
        hold_d     = hold_q;
        hold_pc4_d = hold_pc4_q;
        discard_d  = discard_q;
        disc_tgt_d = disc_tgt_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (take_redirect) begin
                    pc_d       = calc_target;
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    misalign_d = calc_misalign;
                end
            end

            FETCH: begin
                if (take_redirect) begin
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    misalign_d = calc_misalign;
                    if (imem_ready) begin
                        // Data for the old path is dropped; next request uses target
                        pc_d      = calc_target;
                        discard_d = 1'b0;
                    end else begin
                        // Request in flight: keep the address, apply target later
                        discard_d  = 1'b1;
                        disc_tgt_d = calc_target;
                    end
                end else if (discard_q) begin
                    if (imem_ready) begin
                        pc_d      = disc_tgt_q;
                        discard_d = 1'b0;
                    end
                end else if (imem_ready) begin
                    pc_d = seq_pc;
                    if (pc_write) begin
                        instr_d = imem_rdata;
                        pc4_d   = seq_pc;
                        valid_d = 1'b1;
                        count_d = count_q + COUNT_W'(1);
                    end else begin
                        hold_d     = imem_rdata;
                        hold_pc4_d = seq_pc;
                        state_d    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (take_redirect) begin
                    pc_d       = calc_target;
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    misalign_d = calc_misalign;
                    state_d    = FETCH;
                end else if (pc_write) begin
                    instr_d = hold_q;
                    pc4_d   = hold_pc4_q;
                    valid_d = 1'b1;
                    count_d = count_q + COUNT_W'(1);
                    state_d = FETCH;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any outstanding memory transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
            hold_q     <= 32'd0;
            hold_pc4_q <= 32'd0;
            discard_q  <= 1'b0;
            disc_tgt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            hold_pc4_q <= hold_pc4_d;
            discard_q  <= discard_d;
            disc_tgt_q <= disc_tgt_d;
        end
    end

    assign imem_req       = (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign instruction    = instr_q;
    assign pc_plus4       = pc4_q;
    assign if_valid       = valid_q;
    assign fetch_misalign = misalign_q;
    assign fetch_count    = count_q;

endmodule
